// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle shift-add multiply / restoring divide unit with HI/LO registers
// Optional: define MULDIV_SIGNED_EN to build signed MULT/DIV correction in the FIX state.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_in,
    input  logic [WIDTH-1:0] rt_in,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t             state;
    logic [5:0]         iter_cnt;
    logic               is_div;
    logic               div_zero_q;
    logic [WIDTH-1:0]   operand_q;
    logic [WIDTH-1:0]   dividend_q;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

`ifdef MULDIV_SIGNED_EN
    logic rs_neg;
    logic rt_neg;
    logic neg_lo_q;
    logic neg_hi_q;

    assign rs_neg = op[0] & rs_in[WIDTH-1];
    assign rt_neg = op[0] & rt_in[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_in : rs_in;
    assign rt_mag = rt_neg ? -rt_in : rt_in;

    // Multiply negates the full product; divide negates quotient and remainder independently.
    always_comb begin
        if (!is_div) begin
            {res_hi, res_lo} = neg_lo_q ? -acc : acc;
        end else begin
            res_hi = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end
`else
    logic unused_op_sign;

    assign unused_op_sign = op[0];
    assign rs_mag = rs_in;
    assign rt_mag = rt_in;
    assign res_hi = acc[2*WIDTH-1:WIDTH];
    assign res_lo = acc[WIDTH-1:0];
`endif

    // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand_q & {WIDTH{acc[0]}}};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, operand_q};
        if (!is_div) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            iter_cnt    <= '0;
            is_div      <= 1'b0;
            div_zero_q  <= 1'b0;
            operand_q   <= '0;
            dividend_q  <= '0;
            acc         <= '0;
            hi_out      <= '0;
            lo_out      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi_out <= mt_data;
                    if (lo_we) lo_out <= mt_data;
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        iter_cnt   <= '0;
                        is_div     <= op[1];
                        div_zero_q <= op[1] && (rt_in == '0);
                        dividend_q <= rs_in;
                        if (op[1]) begin
                            operand_q <= rt_mag;
                            acc       <= {{WIDTH{1'b0}}, rs_mag};
                        end else begin
                            operand_q <= rs_mag;
                            acc       <= {{WIDTH{1'b0}}, rt_mag};
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_lo_q <= rs_neg ^ rt_neg;
                        neg_hi_q <= rs_neg & op[1];
`endif
                    end
                end
                RUN: begin
                    acc      <= acc_step;
                    iter_cnt <= iter_cnt + 6'd1;
                    if (iter_cnt == LAST_ITER) state <= FIX;
                end
                FIX: begin
                    state       <= DONE;
                    done        <= 1'b1;
                    div_by_zero <= div_zero_q;
                    hi_out      <= div_zero_q ? dividend_q : res_hi;
                    lo_out      <= div_zero_q ? {WIDTH{1'b1}} : res_lo;
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - table-driven scoreboard bench for muldiv_unit
`timescale 1ns/1ps
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_in = '0;
    logic [31:0] rt_in = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] mt_data = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs_in(rs_in), .rt_in(rt_in), .hi_we(hi_we), .lo_we(lo_we),
        .mt_data(mt_data), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("result_hi", 64'(hi_out), 64'(e.hi));
                check("result_lo", 64'(lo_out), 64'(e.lo));
                check("result_dz", 64'(div_by_zero), 64'(e.dz));
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input logic z);
        vec_t v;
        v.op = o; v.rs = a; v.rt = b; v.hi = h; v.lo = l; v.dz = z;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input bit disturb, input bit mt_start);
        int k;
        logic [31:0] h0, l0;
        bit stable;
        sb.push_back(v);
        start = 1'b1; op = v.op; rs_in = v.rs; rt_in = v.rt;
        if (mt_start) begin lo_we = 1'b1; mt_data = 32'hC3C3_3C3C; end
        @(posedge clock); #1;
        start = 1'b0; lo_we = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
        if (mt_start) check("mt_with_start", 64'(lo_out), 64'hC3C3_3C3C);
        h0 = hi_out; l0 = lo_out; stable = 1'b1;
        for (k = 1; k <= 40; k++) begin
            if (disturb && k == 5) begin
                start = 1'b1; op = 2'b00; rs_in = 32'd9; rt_in = 32'd9;
                lo_we = 1'b1; hi_we = 1'b1; mt_data = 32'hA5A5_A5A5;
            end else begin
                start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
            end
            @(posedge clock); #1;
            if (done) break;
            if (hi_out !== h0 || lo_out !== l0) stable = 1'b0;
        end
        check("latency", 64'(k), 64'd33);
        check("hold_during_run", 64'(stable), 64'd1);
        @(posedge clock); #1;
        check("done_one_cycle", {61'd0, done, div_by_zero, busy}, 64'd0);
    endtask

    initial begin
        vecs[0] = mk(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        vecs[1] = mk(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        vecs[2] = mk(2'b00, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0);
        vecs[3] = mk(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        vecs[4] = mk(2'b10, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        vecs[5] = mk(2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
`ifdef MULDIV_SIGNED_EN
        vecs[6] = mk(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        vecs[7] = mk(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        vecs[8] = mk(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        vecs[9] = mk(2'b11, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
`else
        vecs[6] = mk(2'b01, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
        vecs[7] = mk(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
        vecs[8] = mk(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        vecs[9] = mk(2'b11, 32'd100, 32'hFFFF_FFF9, 32'd100, 32'd0, 1'b0);
`endif

        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {29'd0, busy, done, div_by_zero, hi_out}, 64'd0);
        check("reset_lo", 64'(lo_out), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i], 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            logic [63:0] p;
            v.op = (i % 2 == 0) ? 2'b00 : 2'b10;
            v.rs = $urandom;
            v.rt = (i < 4) ? $urandom : $urandom_range(1, 1000);
            if (v.rt == 0) v.rt = 32'd1;
            if (v.op == 2'b00) begin
                p = {32'd0, v.rs} * {32'd0, v.rt};
                v.hi = p[63:32]; v.lo = p[31:0];
            end else begin
                v.hi = v.rs % v.rt; v.lo = v.rs / v.rt;
            end
            v.dz = 1'b0;
            run_op(v, 1'b0, 1'b0);
        end

        lo_we = 1'b1; mt_data = 32'hA5A5_A5A5;
        @(posedge clock); #1;
        lo_we = 1'b0;
        check("mtlo_idle", 64'(lo_out), 64'hA5A5_A5A5);
        hi_we = 1'b1; mt_data = 32'h5A5A_0F0F;
        @(posedge clock); #1;
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi_out), 64'h5A5A_0F0F);

        run_op(mk(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0), 1'b1, 1'b0);
        repeat (40) @(posedge clock);
        #1;
        check("ignored_start_idle", {62'd0, busy, done}, 64'd0);

        run_op(mk(2'b10, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0), 1'b0, 1'b1);

        hi_we = 1'b1; lo_we = 1'b1; mt_data = 32'h1111_1111;
        @(posedge clock); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        start = 1'b1; op = 2'b00; rs_in = 32'hFFFF_FFFF; rt_in = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi_out, lo_out}, 64'd0);
        @(posedge clock); #3;
        reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("abort_no_done", {62'd0, busy, done}, 64'd0);
        run_op(mk(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0), 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
